logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit: the registered successor to our per-gate combinational logic blocks.
- Computes one of eight bitwise operations on WIDTH-bit operands, selected per transaction by opcode.
- Results carry zero, all-ones and parity flags, plus a saturating completed-operation counter.
- Sits between a valid/ready producer (decoder/sequencer) and consumer; two-stage pipeline, full throughput, lossless backpressure.

---
 rtl/logic_unit_pipe_pkg.sv | 20 ++
 rtl/logic_unit_pipe_if.sv | 35 +++
 rtl/logic_op_core.sv | 40 ++++
 rtl/logic_unit_pipe.sv | 103 ++++++++++
 tb/tb_logic_unit_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: opcode width
// and the opcode enumeration used by the datapath and the bus interface.
package logic_unit_pkg;

  // Number of bits carried by every opcode field.
  localparam int OP_W = 3;

  // All eight codes are legal; B is ignored by OP_NOTA and OP_PASSA.
  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_NAND  = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Producer/consumer bus of the logic unit. The master side is whoever
// offers operands and takes results; the slave side is the logic unit.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. The sender holds valid and its payload stable until
// that edge; ready may depend combinationally on the downstream ready.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_a;
  logic [WIDTH-1:0]             in_b;
  logic [logic_unit_pkg::OP_W-1:0] in_op;

  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_y;
  logic [logic_unit_pkg::OP_W-1:0] out_op;
  logic                         out_zero;
  logic                         out_ones;
  logic                         out_parity;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_zero, out_ones, out_parity
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_op, out_zero, out_ones, out_parity
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise operator with result flags. Used in the second
// pipeline stage so flags always describe the same y that gets registered.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  // Select the bitwise operation.
  always_comb begin
    y = a;
    case (op)
      OP_AND:   y = a & b;
      OP_NAND:  y = ~(a & b);
      OP_OR:    y = a | b;
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSA: y = a;
      default:  y = a;
    endcase
  end

  // Flags are pure reductions of the selected result.
  always_comb begin
    zero   = ~|y;
    ones   = &y;
    parity = ^y;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with full throughput, lossless
// backpressure and a saturating count of completed output transfers.
//
// Stage 1 captures operands and opcode; stage 2 evaluates the operation
// and registers the result with its flags. Each stage advances when it is
// empty or when the stage after it is advancing, so in_ready follows
// out_ready combinationally and both stages fill before input stalls.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  logic_unit_pipe_if.slave  bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s1_en;
  logic             s2_en;
  logic             out_fire;

  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             core_ones;
  logic             core_parity;

  // Stage enables: output stage moves when empty or drained this cycle,
  // input stage moves when empty or when the output stage moves.
  assign s2_en    = !bus.out_valid || bus.out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Nothing is accepted while reset is held, even though stage 1 is empty.
  assign bus.in_ready = s1_en && !rst;

  // Stage 1: capture operands; data is don't-care while s1_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_op    <= op_e'(bus.in_op);
    end
  end

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .y      (core_y),
    .zero   (core_zero),
    .ones   (core_ones),
    .parity (core_parity)
  );

  // Stage 2: register result and flags together; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_y      <= '0;
      bus.out_op     <= '0;
      bus.out_zero   <= 1'b0;
      bus.out_ones   <= 1'b0;
      bus.out_parity <= 1'b0;
    end else if (s2_en) begin
      bus.out_valid  <= s1_valid;
      bus.out_y      <= core_y;
      bus.out_op     <= s1_op;
      bus.out_zero   <= core_zero;
      bus.out_ones   <= core_ones;
      bus.out_parity <= core_parity;
    end
  end

  // Completed-transfer counter: clear wins, otherwise count and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (cnt_clr) begin
      op_count <= '0;
    end else if (out_fire && (op_count != CNT_MAX)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe. A second instance with a 4-bit
// counter receives identical stimulus to exercise counter saturation.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  logic cnt_clr;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();
  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus4 ();

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .op_count (op_count)
  );

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus4),
    .cnt_clr  (cnt_clr),
    .op_count (op_count4)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_a      = bus.in_a;
  assign bus4.in_b      = bus.in_b;
  assign bus4.in_op     = bus.in_op;
  assign bus4.out_ready = bus.out_ready;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors: a, b, op, expected y ----------------
  logic [7:0] va [0:23];
  logic [7:0] vb [0:23];
  logic [2:0] vo [0:23];
  logic [7:0] vy [0:23];

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] y);
    va[i] = a; vb[i] = b; vo[i] = op; vy[i] = y;
  endtask

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int n_checks;
  int n_errors;
  int cyc;
  int n_acc, n_xfer, first_acc, first_xfer, last_xfer;
  logic acc, xfer;
  logic smp_in_ready, smp_out_valid;
  logic [7:0] smp_out_y;
  logic [7:0] cur_y;
  logic [2:0] cur_op;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; n_xfer = 0; first_acc = -1; first_xfer = -1; last_xfer = -1;
  endtask

  // One clock: sample at negedge, account handshakes, return at posedge+1.
  task automatic tick();
    logic [10:0] e;
    logic [7:0]  ey;
    @(negedge clk);
    acc           = bus.in_valid && bus.in_ready;
    xfer          = bus.out_valid && bus.out_ready;
    smp_in_ready  = bus.in_ready;
    smp_out_valid = bus.out_valid;
    smp_out_y     = bus.out_y;
    if (acc) begin
      exp_q.push_back({cur_op, cur_y});
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (xfer) begin
      n_xfer++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ey = e[7:0];
        check("out_y", bus.out_y, ey);
        check("out_op", bus.out_op, e[10:8]);
        check("out_zero", bus.out_zero, (ey == 8'h00));
        check("out_ones", bus.out_ones, (ey == 8'hFF));
        check("out_parity", bus.out_parity, ^ey);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.in_a     = va[i];
    bus.in_b     = vb[i];
    bus.in_op    = vo[i];
    cur_y        = vy[i];
    cur_op       = vo[i];
  endtask

  task automatic send(input int i);
    drive(i);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (acc) break;
    end
    check("send_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx;
    n_checks = 0; n_errors = 0; cyc = 0;
    clear_stats();
    cur_y = '0; cur_op = '0;
    acc = 0; xfer = 0;

    // opcode sweep, a=F0 b=CC
    set_vec(0, 8'hF0, 8'hCC, 3'd0, 8'hC0);
    set_vec(1, 8'hF0, 8'hCC, 3'd1, 8'h3F);
    set_vec(2, 8'hF0, 8'hCC, 3'd2, 8'hFC);
    set_vec(3, 8'hF0, 8'hCC, 3'd3, 8'h03);
    set_vec(4, 8'hF0, 8'hCC, 3'd4, 8'h3C);
    set_vec(5, 8'hF0, 8'hCC, 3'd5, 8'hC3);
    set_vec(6, 8'hF0, 8'hCC, 3'd6, 8'h0F);
    set_vec(7, 8'hF0, 8'hCC, 3'd7, 8'hF0);
    // flag corners
    set_vec(8,  8'h0F, 8'hF0, 3'd0, 8'h00);
    set_vec(9,  8'h0F, 8'hF0, 3'd2, 8'hFF);
    set_vec(10, 8'h01, 8'h00, 3'd7, 8'h01);
    // throughput
    set_vec(11, 8'h11, 8'h5A, 3'd7, 8'h11);
    set_vec(12, 8'h22, 8'h5A, 3'd6, 8'hDD);
    set_vec(13, 8'h33, 8'h0F, 3'd0, 8'h03);
    set_vec(14, 8'h44, 8'h0F, 3'd2, 8'h4F);
    set_vec(15, 8'h55, 8'hFF, 3'd4, 8'hAA);
    set_vec(16, 8'h66, 8'h66, 3'd5, 8'hFF);
    set_vec(17, 8'h77, 8'h70, 3'd1, 8'h8F);
    set_vec(18, 8'h88, 8'h08, 3'd3, 8'h77);
    // backpressure
    set_vec(19, 8'hA1, 8'h00, 3'd7, 8'hA1);
    set_vec(20, 8'hB2, 8'h00, 3'd7, 8'hB2);
    set_vec(21, 8'hC3, 8'h00, 3'd6, 8'h3C);
    set_vec(22, 8'hD4, 8'h0F, 3'd0, 8'h04);
    set_vec(23, 8'hE5, 8'h1A, 3'd2, 8'hFF);

    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_op", bus.out_op, 0);
    check("rst_flags", {bus.out_zero, bus.out_ones, bus.out_parity}, 0);
    check("rst_op_count", op_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // opcode sweep and flag corners, back-to-back
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) send(i);
    drain();
    check("sweep_count", op_count, 11);

    // throughput and latency
    clear_counters();
    check("clr_count", op_count, 0);
    clear_stats();
    for (int i = 11; i <= 18; i++) send(i);
    drain();
    check("tp_latency", first_xfer - first_acc, 2);
    check("tp_back_to_back", last_xfer - first_xfer, 7);
    check("tp_xfers", n_xfer, 8);
    check("tp_op_count", op_count, 8);

    // backpressure: out_ready low for 6 cycles, in_valid held high
    clear_stats();
    bus.out_ready = 1'b0;
    idx = 19;
    drive(idx);
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t >= 2) begin
        check("bp_in_ready_low", smp_in_ready, 0);
        check("bp_out_valid", smp_out_valid, 1);
        check("bp_y_stable", smp_out_y, 8'hA1);
      end
      if (acc && idx < 23) begin
        idx++;
        drive(idx);
      end
    end
    check("bp_accepted", n_acc, 2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && n_acc < 5; k++) begin
      tick();
      if (acc) begin
        if (idx < 23) begin
          idx++;
          drive(idx);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    drain();
    check("bp_xfers", n_xfer, 5);

    // counter saturation on the 4-bit instance
    clear_counters();
    for (int i = 0; i < 20; i++) send(i % 8);
    drain();
    check("cnt16_value", op_count, 20);
    check("cnt4_saturated", op_count4, 15);

    // clear in the same cycle as an output handshake
    send(3);
    tick();
    check("clr_race_out_valid", bus.out_valid, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_race_xfer", xfer, 1);
    check("clr_race_count", op_count, 0);
    check("clr_race_count4", op_count4, 0);

    // reset with both stages full
    send(5);
    drain();
    check("pre_rst_count", op_count, 1);
    bus.out_ready = 1'b0;
    clear_stats();
    drive(6);
    tick();
    drive(7);
    tick();
    bus.in_valid = 1'b0;
    check("fill_accepted", n_acc, 2);
    check("fill_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_op_count", op_count, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_post_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("no_stale_valid", smp_out_valid, 0);
    end
    send(4);
    drain();
    check("final_count", op_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
